// File: rtl/fac.sv
// Full-adder cell with registered sum/carry and a saturating carry-event counter.
// Optional redundant sum/carry self-check enabled by defining FAC_CHECK_EN.
`timescale 1ns/1ps
module fac #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  input  logic             ci,
  output logic             z,
  output logic             co,
  output logic             g,
  output logic             p,
  output logic             z_q,
  output logic             co_q,
  output logic [CNT_W-1:0] co_cnt
`ifdef FAC_CHECK_EN
  ,
  output logic             err
`endif
);

  // Adder path is purely combinational so chained cells ripple even in reset.
  assign g  = x & y;
  assign p  = x ^ y;
  assign z  = p ^ ci;
  assign co = g | (ci & p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q  <= 1'b0;
      co_q <= 1'b0;
    end else begin
      z_q  <= z;
      co_q <= co;
    end
  end

  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      co_cnt <= '0;
    else if (co && !(&co_cnt))
      co_cnt <= co_cnt + 1'b1;
  end

`ifdef FAC_CHECK_EN
  // Redundant mux-based formulation of the same cell, compared every edge.
  logic red_sum, red_carry;
  assign red_sum   = ci ? ~p : p;
  assign red_carry = p ? ci : g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if ({red_carry, red_sum} != {co, z})
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fac.sv
// Randomized self-checking bench for fac: arithmetic reference model plus
// literal checks for reset, saturation, async reset and a 16-cell ripple chain.
`timescale 1ns/1ps
module tb_fac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x = 1'b0, y = 1'b0, ci = 1'b0;
  logic z, co, g, p, z_q, co_q;
  logic [15:0] co_cnt;
  logic z4, co4, g4, p4, zq4, coq4;
  logic [3:0] cnt4;
`ifdef FAC_CHECK_EN
  logic err, err4;
  logic [15:0] c_err;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  fac #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .ci(ci),
    .z(z), .co(co), .g(g), .p(p), .z_q(z_q), .co_q(co_q), .co_cnt(co_cnt)
`ifdef FAC_CHECK_EN
    , .err(err)
`endif
  );

  fac #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .x(x), .y(y), .ci(ci),
    .z(z4), .co(co4), .g(g4), .p(p4), .z_q(zq4), .co_q(coq4), .co_cnt(cnt4)
`ifdef FAC_CHECK_EN
    , .err(err4)
`endif
  );

  // 16-cell ripple-carry chain
  logic [15:0] ca, cb, cs, cg, cp, czq, ccoq;
  logic [15:0][15:0] ccnt;
  logic [16:0] cc;
  assign cc[0] = 1'b0;
  for (genvar i = 0; i < 16; i++) begin : g_chain
    fac #(.CNT_W(16)) u (
      .clk(clk), .rst(rst), .x(ca[i]), .y(cb[i]), .ci(cc[i]),
      .z(cs[i]), .co(cc[i+1]), .g(cg[i]), .p(cp[i]), .z_q(czq[i]),
      .co_q(ccoq[i]), .co_cnt(ccnt[i])
`ifdef FAC_CHECK_EN
      , .err(c_err[i])
`endif
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: registered outputs are the arithmetic sum seen at the last edge.
  logic m_zq, m_coq;
  int   m_cnt, m_cnt4;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_zq <= 1'b0; m_coq <= 1'b0; m_cnt <= 0; m_cnt4 <= 0;
    end else begin
      int s;
      s = int'(x) + int'(y) + int'(ci);
      m_zq  <= s[0];
      m_coq <= s[1];
      if (s >= 2 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (s >= 2 && m_cnt4 < 15) m_cnt4 <= m_cnt4 + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int s;
      s = int'(x) + int'(y) + int'(ci);
      check("z",      32'(z),      32'(s % 2));
      check("co",     32'(co),     32'(s / 2));
      check("g",      32'(g),      32'(x & y));
      check("p",      32'(p),      32'(x ^ y));
      check("z_q",    32'(z_q),    32'(m_zq));
      check("co_q",   32'(co_q),   32'(m_coq));
      check("co_cnt", 32'(co_cnt), 32'(m_cnt));
      check("cnt4",   32'(cnt4),   32'(m_cnt4));
    end
  end

  task automatic drive(input logic [2:0] v);
    {x, y, ci} = v;
  endtask

  initial begin
    drive(3'b000);
    #1;
    check("rst_z_q", 32'(z_q), 0);
    check("rst_co_q", 32'(co_q), 0);
    check("rst_cnt", 32'(co_cnt), 0);

    // Exhaustive sweep while in reset: combinational path must still work.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive(v);
      #1;
      check("sweep_sum", 32'({co, z}), 32'(int'(v[2]) + int'(v[1]) + int'(v[0])));
    end
    drive(3'b111); #1;
    check("lit_111", 32'({co, z}), 32'h3);
    drive(3'b100); #1;
    check("lit_100", 32'({co, z}), 32'h1);

    // Registers stay cleared across edges while rst is high.
    drive(3'b111);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_zq", 32'(z_q), 0);
    check("rst_hold_cnt", 32'(co_cnt), 0);

    // Ripple chain
    ca = 16'h0007; cb = 16'h0002; #1;
    check("chain_7p2", 32'(cs), 32'h0009);
    check("chain_7p2_c", 32'(cc[16]), 0);
    ca = 16'hFFFF; cb = 16'h0001; #1;
    check("chain_ffff", 32'(cs), 32'h0000);
    check("chain_ffff_c", 32'(cc[16]), 1);
    for (int i = 0; i < 20; i++) begin
      ca = 16'($urandom); cb = 16'($urandom); #1;
      check("chain_rand", 32'({cc[16], cs}), 32'(ca) + 32'(cb));
    end

    // Hold x=y=1 from reset release.
    @(negedge clk); #1;
    drive(3'b110);
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("hold3_cnt", 32'(co_cnt), 3);
    check("hold3_coq", 32'(co_q), 1);
    repeat (17) @(posedge clk);
    @(negedge clk); #1;
    check("sat_cnt4", 32'(cnt4), 15);
    check("cnt20", 32'(co_cnt), 20);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("sat_stay4", 32'(cnt4), 15);
    check("cnt25", 32'(co_cnt), 25);

    // Random phase, including mid-cycle input changes that must not reach registers.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      drive(3'($urandom));
      if (($urandom % 4) == 0) begin
        @(posedge clk); #2;
        drive(3'($urandom));
      end
    end

    // Async reset of a saturated counter, between edges.
    @(negedge clk); #1;
    check("pre_rst_sat4", 32'(cnt4), 15);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("arst_cnt4", 32'(cnt4), 0);
    check("arst_cnt", 32'(co_cnt), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    drive(3'b110);

    // Count to 5 then reset asynchronously mid-cycle.
    repeat (5) @(posedge clk);
    #1;
    check("cnt5", 32'(co_cnt), 5);
    drive(3'b111);
    #1;
    rst = 1'b1; #1;
    check("arst5_cnt", 32'(co_cnt), 0);
    check("arst5_zq", 32'(z_q), 0);
    check("arst5_coq", 32'(co_q), 0);
    check("arst5_zco", 32'({co, z}), 32'h3);
    drive(3'b011); #1;
    check("arst5_track", 32'({co, z}), 32'h2);

    // First capture only after reset release.
    @(negedge clk); #1;
    drive(3'b100);
    rst = 1'b0;
    #1;
    check("rel_zq_pre", 32'(z_q), 0);
    @(posedge clk); #1;
    check("rel_zq_first", 32'(z_q), 1);

`ifdef FAC_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      drive(3'(i));
    end
    @(negedge clk); #1;
    check("chk_err0", 32'(err), 0);
    chk_on = 1'b0;
    drive(3'b000);
    force dut.red_sum = 1'b1;
    @(posedge clk); #1;
    release dut.red_sum;
    check("chk_err_set", 32'(err), 1);
    repeat (3) @(posedge clk);
    #1;
    check("chk_err_sticky", 32'(err), 1);
    rst = 1'b1; #1;
    check("chk_err_clr", 32'(err), 0);
    rst = 1'b0;
`endif

    chk_on = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fac.md
FAC -- requirements
Module: fac

Interface
- REQ-001: Parameter CNT_W, default 16: width of the carry-event counter (legal range 4..32).
- REQ-002: clk, input, 1: sole clock; all state updates on rising edge.
- REQ-003: rst, input, 1: asynchronous, active-high reset.
- REQ-004: x, input, 1: addend bit A.
- REQ-005: y, input, 1: addend bit B.
- REQ-006: ci, input, 1: carry-in bit.
- REQ-007: z, output, 1: sum bit, combinational.
- REQ-008: co, output, 1: carry-out bit, combinational.
- REQ-009: g, output, 1: generate, x AND y, combinational.
- REQ-010: p, output, 1: propagate, x XOR y, combinational.
- REQ-011: z_q, output, 1: z registered once.
- REQ-012: co_q, output, 1: co registered once.
- REQ-013: co_cnt, output, CNT_W: saturating count of cycles with co=1.
- REQ-014: err, output, 1: sticky self-check mismatch flag; exists only when FAC_CHECK_EN is defined.

Function
- REQ-015: z SHALL equal x XOR y XOR ci, with zero-cycle latency and no dependence on clk or rst.
- REQ-016: co SHALL equal (x AND y) OR (ci AND (x XOR y)), with zero-cycle latency.
- REQ-017: {co,z} SHALL equal the 2-bit arithmetic sum x+y+ci for all 8 input combinations.
- REQ-018: z, co, g and p SHALL be valid during reset, so that chained cells form a purely combinational ripple-carry path.
- REQ-019: z_q and co_q SHALL capture z and co on every rising clk edge, giving 1-cycle latency.
- REQ-020: co_cnt SHALL increment by 1 on each rising edge where co=1.
- REQ-021: co_cnt SHALL hold at all-ones (2^CNT_W-1) and SHALL NOT wrap.
- REQ-022: co_cnt SHALL hold its value on edges where co=0.
- REQ-023: Inputs changing between edges SHALL affect only the combinational outputs; registered outputs sample only at the edge.

Reset
- REQ-024: Asserting rst SHALL immediately, without waiting for a clock edge, force z_q=0, co_q=0, co_cnt=0 and err=0.
- REQ-025: While rst is high, all registers SHALL hold their reset values regardless of clk.
- REQ-026: The first capture after reset SHALL occur on the first rising clk edge after rst deasserts.
- REQ-027: Reset asserted mid-count SHALL clear co_cnt, including when co_cnt is saturated.

Configuration
- REQ-028: Macro FAC_CHECK_EN.
- REQ-029: When FAC_CHECK_EN is defined, the block SHALL compute a redundant sum and carry, registered each edge:
  - sum = ci ? NOT p : p
  - carry = p ? ci : g
- REQ-030: When FAC_CHECK_EN is defined and the redundant pair differs from {co,z} at a rising edge, err SHALL be set to 1 and SHALL stay 1 until reset.
- REQ-031: When FAC_CHECK_EN is undefined, the err port and all checker logic SHALL be absent, and the rest of the behaviour SHALL be unchanged.

Verification
- REQ-032: Exhaustive check: apply all 8 {x,y,ci} combinations combinationally -> {co,z} = x+y+ci each time (e.g. 1,1,1 -> co=1, z=1; 1,0,0 -> co=0, z=1).
- REQ-033: Chain 16 cells with ci=0, A=7, B=2 -> sum 0x0009, final carry 0; A=0xFFFF, B=1 -> sum 0x0000, final carry 1.
- REQ-034: Hold x=1, y=1 for 3 edges after reset -> co_q=1 from the first edge and co_cnt=3.
- REQ-035: With CNT_W=4, hold co=1 for 20 edges -> co_cnt=15 and stays 15.
- REQ-036: Assert rst asynchronously between edges with co_cnt=5 -> co_cnt=0, z_q=0, co_q=0 immediately; z and co still track the inputs.
- REQ-037: With FAC_CHECK_EN defined, run the exhaustive sweep -> err remains 0; force a mismatch in simulation -> err=1, sticky until rst.
